operand_fetch: RTL
==================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock; single clock domain.
REQ-002 SHALL have: reset  in  1  synchronous, active-high; sampled on rising clk edge only.
REQ-003 SHALL have: if_fsm_instr_finish  in  1  pulse; a complete instruction is present on instruction/if_fsm_num_bytes/if_of_pc.
REQ-004 SHALL have: if_fsm_num_bytes  in  3  instruction length, 1..4.
REQ-005 SHALL have: instruction  in  32  byte0=[7:0] (first fetched) .. byte3=[31:24]; unused bytes zero.
REQ-006 SHALL have: if_of_pc  in  16  address of the byte following the instruction; valid with finish.
REQ-007 SHALL have: alu_of_flags  in  8  Z80 F register: S=7, Z=6, H=4, P/V=2, N=1, C=0.
REQ-008 SHALL have: ex_of_ready  in  1  execute stage accepts the issued instruction this cycle.
REQ-009 SHALL have: of_if_pc  out  16  branch target for fetch.
REQ-010 SHALL have: of_fsm_pc_modify  out  1  one-cycle pulse; of_if_pc is valid and is to be loaded as the new PC.
REQ-011 SHALL have: of_ex_valid  out  1  issued instruction valid; held until accepted.
REQ-012 SHALL have: of_ex_opcode  out  16  {prefix, opcode}; prefix 8'h00 when unprefixed.
REQ-013 SHALL have: of_ex_imm16  out  16  immediate operand.
REQ-014 SHALL have: of_ex_disp  out  8  index displacement.
REQ-015 SHALL have: of_ex_num_bytes  out  3  copy of the captured length.
REQ-016 SHALL have: of_busy  out  1  high in every state except IDLE; fetch controller holds off fetch while high.
REQ-017 SHALL have: of_overrun  out  1  sticky error flag.

Function
REQ-018 SHALL implement states IDLE, DECODE, ISSUE; transitions occur only on rising clk.
REQ-019 IDLE + finish=1 SHALL capture instruction, num_bytes, if_of_pc, alu_of_flags, then go to DECODE.
REQ-020 DECODE SHALL last exactly one cycle; branch resolution uses the flags captured in REQ-019.
REQ-021 Prefixed = byte0 in {CB, DD, ED, FD}; prefixed opcode = {byte0, byte1}; unprefixed opcode = {8'h00, byte0}.
REQ-022 Operand extraction, unprefixed: len 1 -> imm16=0; len 2 -> imm16={8'h00, byte1}; len 3 -> imm16={byte2, byte1} (little-endian); disp=0.
REQ-023 Operand extraction, prefixed: len 2 -> imm16=0, disp=0; len 3 -> disp=byte2, imm16=0; len 4 -> disp=byte2, imm16={byte3, byte2}.
REQ-024 Branch opcodes resolved here (unprefixed only): C3 JP nn; C2/CA/D2/DA/E2/EA/F2/FA JP cc,nn; 18 JR e; 20/28/30/38 JR cc,e.
REQ-025 Condition cc = opcode[5:3]: 0 NZ (Z=0), 1 Z, 2 NC, 3 C, 4 PO (P/V=0), 5 PE, 6 P (S=0), 7 M; for JR, only cc 0..3 apply.
REQ-026 JP target = {byte2, byte1}; JR target = captured if_of_pc + sign-extended byte1, modulo 2^16 (wrap-around, no carry out).
REQ-027 Branch in DECODE: if taken, drive of_if_pc=target and pulse of_fsm_pc_modify for that one cycle; taken or not, go to IDLE with no of_ex_valid (branch fully consumed).
REQ-028 Non-branch in DECODE SHALL go to ISSUE; ISSUE drives of_ex_valid=1 with all of_ex_* stable.
REQ-029 ISSUE + ex_of_ready=1 SHALL deassert valid next cycle and go to IDLE; ex_of_ready=0 holds ISSUE indefinitely.
REQ-030 Minimum finish-to-valid latency: 2 cycles; one instruction in flight; back-to-back finish accepted the cycle after return to IDLE.
REQ-031 finish=1 while not IDLE SHALL be ignored (no capture, no state change) and SHALL set of_overrun.
REQ-032 Captured num_bytes of 0 or >4 SHALL be discarded in DECODE (go to IDLE, no valid, no pc_modify) and SHALL set of_overrun.
REQ-033 DJNZ (10), CALL, RET, JP (HL) SHALL be issued to EX, not resolved here.

Reset
REQ-034 reset=1 SHALL force IDLE and zero every output, including of_overrun, in the same edge; this takes priority over all other inputs.
REQ-035 Reset asserted mid-DECODE or mid-ISSUE SHALL abort the instruction, with no pc_modify pulse and no valid in the following cycle.
REQ-036 of_overrun SHALL clear only on reset.

Verification
REQ-037 Instruction 0x00003E (LD A,n; byte0=3E, byte1=00), len 2 -> opcode 003E, imm16 0000, valid at finish+2, held with ready=0 for 5 cycles, dropped the cycle after ready=1.
REQ-038 JR -2 (18 FE), if_of_pc=0x0001 -> of_if_pc=0xFFFF, one pc_modify pulse, no valid.
REQ-039 JP Z,0x1234 (CA 34 12): Z=1 -> pc_modify, of_if_pc=1234; Z=0 -> no pulse, no valid, back to IDLE.
REQ-040 LD (IX+5),0x7A (DD 36 05 7A) -> opcode DD36, disp 05, imm16 7A05, num_bytes 4.
REQ-041 Second finish during ISSUE -> ignored, of_overrun=1 until reset, first instruction still delivered intact.
REQ-042 reset=1 in ISSUE -> next cycle valid=0, busy=0, overrun=0, state IDLE.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: captures a completed Z80 instruction from the fetch stage.
// It decodes the opcode and operands, resolves JP/JR branches locally, and
// issues every other instruction to the execute stage with a valid/ready
// handshake. Only one instruction is in flight at a time.
//
// Ports
//   clk, reset               clock, synchronous active-high reset
//   if_fsm_instr_finish      pulse: instruction/if_fsm_num_bytes/if_of_pc valid
//   if_fsm_num_bytes [2:0]   instruction length (1..4)
//   instruction [31:0]       byte0 in [7:0] .. byte3 in [31:24]
//   if_of_pc [15:0]          address of the byte after the instruction
//   alu_of_flags [7:0]       F register (S=7 Z=6 H=4 P/V=2 N=1 C=0)
//   ex_of_ready              execute accepts the issued instruction
//   of_if_pc [15:0]          branch target, valid with of_fsm_pc_modify
//   of_fsm_pc_modify         one-cycle pulse: load of_if_pc as the new PC
//   of_ex_valid              issued instruction valid, held until accepted
//   of_ex_opcode [15:0]      {prefix, opcode}
//   of_ex_imm16 [15:0]       immediate operand
//   of_ex_disp [7:0]         index displacement
//   of_ex_num_bytes [2:0]    captured instruction length
//   of_busy                  high whenever not IDLE
//   of_overrun               sticky error flag, cleared only by reset
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_fsm_instr_finish,
  input  logic [2:0]  if_fsm_num_bytes,
  input  logic [31:0] instruction,
  input  logic [15:0] if_of_pc,
  input  logic [7:0]  alu_of_flags,
  input  logic        ex_of_ready,
  output logic [15:0] of_if_pc,
  output logic        of_fsm_pc_modify,
  output logic        of_ex_valid,
  output logic [15:0] of_ex_opcode,
  output logic [15:0] of_ex_imm16,
  output logic [7:0]  of_ex_disp,
  output logic [2:0]  of_ex_num_bytes,
  output logic        of_busy,
  output logic        of_overrun
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ISSUE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  nb_q, nb_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  flags_q, flags_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        pc_mod_q, pc_mod_d;
  logic        valid_q, valid_d;
  logic [15:0] opcode_q, opcode_d;
  logic [15:0] imm_q, imm_d;
  logic [7:0]  disp_q, disp_d;
  logic [2:0]  exnb_q, exnb_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;

  logic [7:0]  b0, b1, b2, b3;
  logic        prefixed, is_jp, is_jpcc, is_jr, is_jrcc, is_branch;
  logic [2:0]  cc;
  logic        cond_ok, taken, len_bad;
  logic [15:0] dec_opcode, dec_imm, target;
  logic [7:0]  dec_disp;
  logic        unused_flag_bits;

  assign {b3, b2, b1, b0} = instr_q;
  // H and N never steer a branch.
  assign unused_flag_bits = ^{flags_q[5:3], flags_q[1]};

  // Decode of the captured instruction: opcode, operands, branch resolution.
  always_comb begin
    prefixed   = (b0 == 8'hCB) || (b0 == 8'hDD) || (b0 == 8'hED) || (b0 == 8'hFD);
    dec_opcode = prefixed ? {b0, b1} : {8'h00, b0};
    dec_imm    = 16'h0000;
    dec_disp   = 8'h00;
    if (prefixed) begin
      if (nb_q == 3'd3) begin
        dec_disp = b2;
      end else if (nb_q == 3'd4) begin
        dec_disp = b2;
        dec_imm  = {b3, b2};
      end
    end else begin
      if (nb_q == 3'd2)      dec_imm = {8'h00, b1};
      else if (nb_q >= 3'd3) dec_imm = {b2, b1};
    end

    is_jp     = (b0 == 8'hC3);
    is_jpcc   = ((b0 & 8'hC7) == 8'hC2);
    is_jr     = (b0 == 8'h18);
    is_jrcc   = ((b0 & 8'hE7) == 8'h20);
    is_branch = !prefixed && (is_jp || is_jpcc || is_jr || is_jrcc);
    // JR cc only encodes NZ/Z/NC/C in bits [4:3].
    cc = is_jrcc ? {1'b0, b0[4:3]} : b0[5:3];
    case (cc)
      3'd0:    cond_ok = !flags_q[6];
      3'd1:    cond_ok =  flags_q[6];
      3'd2:    cond_ok = !flags_q[0];
      3'd3:    cond_ok =  flags_q[0];
      3'd4:    cond_ok = !flags_q[2];
      3'd5:    cond_ok =  flags_q[2];
      3'd6:    cond_ok = !flags_q[7];
      default: cond_ok =  flags_q[7];
    endcase
    taken  = is_jp || is_jr || ((is_jpcc || is_jrcc) && cond_ok);
    target = (is_jr || is_jrcc) ? 16'(pc_q + {{8{b1[7]}}, b1}) : {b2, b1};
    len_bad = (nb_q == 3'd0) || (nb_q > 3'd4);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    nb_d     = nb_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    if_pc_d  = if_pc_q;
    pc_mod_d = 1'b0;
    valid_d  = valid_q;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    disp_d   = disp_q;
    exnb_d   = exnb_q;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (if_fsm_instr_finish) begin
          instr_d = instruction;
          nb_d    = if_fsm_num_bytes;
          pc_d    = if_of_pc;
          flags_d = alu_of_flags;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (len_bad) begin
          ovr_d   = 1'b1;
          state_d = IDLE;
        end else if (is_branch) begin
          state_d = IDLE;
          if (taken) begin
            pc_mod_d = 1'b1;
            if_pc_d  = target;
          end
        end else begin
          valid_d  = 1'b1;
          opcode_d = dec_opcode;
          imm_d    = dec_imm;
          disp_d   = dec_disp;
          exnb_d   = nb_q;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (ex_of_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A finish while busy is dropped and flagged.
    if (if_fsm_instr_finish && (state_q != IDLE)) ovr_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= 32'h0;
      nb_q     <= 3'd0;
      pc_q     <= 16'h0;
      flags_q  <= 8'h0;
      if_pc_q  <= 16'h0;
      pc_mod_q <= 1'b0;
      valid_q  <= 1'b0;
      opcode_q <= 16'h0;
      imm_q    <= 16'h0;
      disp_q   <= 8'h0;
      exnb_q   <= 3'd0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      nb_q     <= nb_d;
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      if_pc_q  <= if_pc_d;
      pc_mod_q <= pc_mod_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      disp_q   <= disp_d;
      exnb_q   <= exnb_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  assign of_if_pc         = if_pc_q;
  assign of_fsm_pc_modify = pc_mod_q;
  assign of_ex_valid      = valid_q;
  assign of_ex_opcode     = opcode_q;
  assign of_ex_imm16      = imm_q;
  assign of_ex_disp       = disp_q;
  assign of_ex_num_bytes  = exnb_q;
  assign of_busy          = busy_q;
  assign of_overrun       = ovr_q;

endmodule
